// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 5-bit opcode map and branch predictor FSM states.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] ADD    = 5'd0;
    localparam logic [OPCODE_W-1:0] SUB    = 5'd1;
    localparam logic [OPCODE_W-1:0] AND    = 5'd2;
    localparam logic [OPCODE_W-1:0] OR     = 5'd3;
    localparam logic [OPCODE_W-1:0] XOR    = 5'd4;
    localparam logic [OPCODE_W-1:0] SLL    = 5'd5;
    localparam logic [OPCODE_W-1:0] SRL    = 5'd6;
    localparam logic [OPCODE_W-1:0] SRA    = 5'd7;
    localparam logic [OPCODE_W-1:0] SLT    = 5'd8;
    localparam logic [OPCODE_W-1:0] SLTU   = 5'd9;
    localparam logic [OPCODE_W-1:0] ADDI   = 5'd10;
    localparam logic [OPCODE_W-1:0] ANDI   = 5'd11;
    localparam logic [OPCODE_W-1:0] ORI    = 5'd12;
    localparam logic [OPCODE_W-1:0] XORI   = 5'd13;
    localparam logic [OPCODE_W-1:0] SLLI   = 5'd14;
    localparam logic [OPCODE_W-1:0] SRLI   = 5'd15;
    localparam logic [OPCODE_W-1:0] SRAI   = 5'd16;
    localparam logic [OPCODE_W-1:0] LUI    = 5'd17;
    localparam logic [OPCODE_W-1:0] LW     = 5'd18;
    localparam logic [OPCODE_W-1:0] SW     = 5'd19;
    localparam logic [OPCODE_W-1:0] LB     = 5'd20;
    localparam logic [OPCODE_W-1:0] SB     = 5'd21;
    localparam logic [OPCODE_W-1:0] MOV    = 5'd22;
    localparam logic [OPCODE_W-1:0] BT     = 5'd23;
    localparam logic [OPCODE_W-1:0] BF     = 5'd24;
    localparam logic [OPCODE_W-1:0] JAL    = 5'd25;
    localparam logic [OPCODE_W-1:0] JALR   = 5'd26;
    localparam logic [OPCODE_W-1:0] NOP    = 5'd27;
    localparam logic [OPCODE_W-1:0] HALT   = 5'd28;
    localparam logic [OPCODE_W-1:0] ECALL  = 5'd29;
    localparam logic [OPCODE_W-1:0] EBREAK = 5'd30;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_state_t;

    // Conditional branches that consult the history table.
    function automatic logic is_cond_branch(input logic [OPCODE_W-1:0] op);
        return (op == BT) || (op == BF);
    endfunction

endpackage

// File: rtl/bht_sat_counter_array.sv
// Branch history table storage: saturating counters with an init write port,
// a training port and an asynchronous read port (read sees pre-update value).
module bht_sat_counter_array #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_idx,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr_c
);

    localparam int unsigned DEPTH = 2**IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2**(CTR_W-1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;

    logic [CTR_W-1:0] ctr_mem [DEPTH];
    logic [CTR_W-1:0] upd_cur_c;
    logic [CTR_W-1:0] upd_next_c;

    assign rd_ctr_c  = ctr_mem[rd_idx];
    assign upd_cur_c = ctr_mem[upd_idx];

    // Saturating step toward the resolved direction.
    always_comb begin
        upd_next_c = upd_cur_c;
        if (upd_taken) begin
            if (upd_cur_c != CTR_MAX) begin
                upd_next_c = upd_cur_c + CTR_W'(1);
            end
        end else begin
            if (upd_cur_c != CTR_MIN) begin
                upd_next_c = upd_cur_c - CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            ctr_mem[init_idx] <= CTR_INIT;
        end else if (upd_we) begin
            ctr_mem[upd_idx] <= upd_next_c;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// BHT-based branch predictor with BTFNT fallback while the table initialises.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predictor_bht
    import cpu_pkg::*;
#(
    parameter int unsigned OFFSET_W = 17,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned CTR_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                halted,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [PC_W-1:0]     pc,
    input  logic [OFFSET_W-1:0] branch_target,
    output logic [OFFSET_W-1:0] predicted_offset,
    output logic [OFFSET_W-1:0] not_predicted_offset,
    output logic                pred_taken,
    input  logic                upd_valid,
    input  logic [PC_W-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic                upd_pred_taken,
    output logic                ready
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int unsigned DEPTH = 2**IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    bpu_state_t          state_q;
    bpu_state_t          state_d;
    logic [IDX_W-1:0]    init_idx_q;
    logic                init_we_c;
    logic                upd_we_c;
    logic [CTR_W-1:0]    rd_ctr_c;
    logic                is_br_c;
    logic                is_jal_c;
    logic                taken_c;
    logic [OFFSET_W-1:0] npo_id_c;
    logic [OFFSET_W-1:0] npo_d_c;
    logic                pt_d_c;

    // FSM state and init pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_idx_q <= init_idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        init_we_c = 1'b0;
        upd_we_c  = 1'b0;
        case (state_q)
            INIT: begin
                init_we_c = !reset;
                if (init_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                upd_we_c = upd_valid && !reset;
            end
            default: state_d = INIT;
        endcase
    end

    bht_sat_counter_array #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_bht (
        .clk       (clk),
        .init_we   (init_we_c),
        .init_idx  (init_idx_q),
        .upd_we    (upd_we_c),
        .upd_idx   (upd_pc[IDX_W-1:0]),
        .upd_taken (upd_taken),
        .rd_idx    (pc[IDX_W-1:0]),
        .rd_ctr_c  (rd_ctr_c)
    );

    assign is_br_c  = is_cond_branch(opcode);
    assign is_jal_c = (opcode == JAL);
    assign taken_c  = (state_q == RUN) ? rd_ctr_c[CTR_W-1] : branch_target[OFFSET_W-1];

    // Offset arithmetic for fetch redirect and EX recovery.
    always_comb begin
        predicted_offset = OFFSET_W'(1);
        npo_id_c         = '0;
        pt_d_c           = 1'b0;
        if (is_br_c) begin
            pt_d_c = taken_c;
            if (taken_c) begin
                predicted_offset = branch_target;
                npo_id_c         = OFFSET_W'(0) - branch_target;
            end else begin
                npo_id_c = branch_target - OFFSET_W'(2);
            end
        end else if (is_jal_c) begin
            predicted_offset = branch_target;
            pt_d_c           = 1'b1;
        end
        npo_d_c = is_jal_c ? (npo_id_c - branch_target + OFFSET_W'(1)) : npo_id_c;
    end

    // Registered stage toward EX; ready follows the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            not_predicted_offset <= '0;
            pred_taken           <= 1'b0;
            ready                <= 1'b0;
        end else begin
            ready <= (state_d == RUN);
            if (!(stall || halted)) begin
                not_predicted_offset <= npo_d_c;
                pred_taken           <= pt_d_c;
            end
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_we_c) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 32'(1);
            end
            if ((upd_taken != upd_pred_taken) && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'(1);
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc, upd_pc};
`else
    // Upper PC bits and the accompanying prediction only matter to statistics.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc, upd_pc, upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht against a behavioural table model.
module tb_branch_predictor_bht;
    import cpu_pkg::*;

    localparam int OFFSET_W = 17;
    localparam int PC_W     = 16;
    localparam int IDX_W    = 6;
    localparam int CTR_W    = 2;
    localparam int DEPTH    = 1 << IDX_W;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int HALF     = 1 << (CTR_W - 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                stall;
    logic                halted;
    logic [4:0]          opcode;
    logic [PC_W-1:0]     pc;
    logic [OFFSET_W-1:0] branch_target;
    logic [OFFSET_W-1:0] predicted_offset;
    logic [OFFSET_W-1:0] not_predicted_offset;
    logic                pred_taken;
    logic                upd_valid;
    logic [PC_W-1:0]     upd_pc;
    logic                upd_taken;
    logic                upd_pred_taken;
    logic                ready;
`ifdef BPU_STATS_EN
    logic [31:0]         stat_branches;
    logic [31:0]         stat_mispredicts;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int                  m_ctr [DEPTH];
    bit                  m_run;
    int                  m_init_cnt;
    logic [OFFSET_W-1:0] m_npo;
    bit                  m_pt;
    bit                  m_ready;
    logic [31:0]         m_sb;
    logic [31:0]         m_sm;

    branch_predictor_bht #(
        .OFFSET_W (OFFSET_W),
        .PC_W     (PC_W),
        .IDX_W    (IDX_W),
        .CTR_W    (CTR_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall                (stall),
        .halted               (halted),
        .opcode               (opcode),
        .pc                   (pc),
        .branch_target        (branch_target),
        .predicted_offset     (predicted_offset),
        .not_predicted_offset (not_predicted_offset),
        .pred_taken           (pred_taken),
        .upd_valid            (upd_valid),
        .upd_pc               (upd_pc),
        .upd_taken            (upd_taken),
        .upd_pred_taken       (upd_pred_taken),
        .ready                (ready)
`ifdef BPU_STATS_EN
        ,
        .stat_branches        (stat_branches),
        .stat_mispredicts     (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_br();
        return (opcode == BT) || (opcode == BF);
    endfunction

    function automatic bit m_taken();
        if (m_run) return m_ctr[int'(pc) % DEPTH] >= HALF;
        return branch_target[OFFSET_W-1];
    endfunction

    function automatic logic [OFFSET_W-1:0] m_pred();
        int bt = int'($signed(branch_target));
        if (m_is_br()) return m_taken() ? OFFSET_W'(bt) : OFFSET_W'(1);
        if (opcode == JAL) return OFFSET_W'(bt);
        return OFFSET_W'(1);
    endfunction

    // One clock of the reference: all decisions use pre-edge state.
    task automatic model_step();
        int  bt = int'($signed(branch_target));
        int  npo;
        bit  pt;
        int  ui;
        if (reset) begin
            m_run = 0; m_init_cnt = 0; m_npo = '0; m_pt = 0; m_ready = 0;
            m_sb = '0; m_sm = '0;
            return;
        end
        if (m_is_br()) begin
            pt  = m_taken();
            npo = pt ? -bt : bt - 2;
        end else if (opcode == JAL) begin
            pt = 1; npo = -bt + 1;
        end else begin
            pt = 0; npo = 0;
        end
        if (!stall && !halted) begin
            m_npo = OFFSET_W'(npo);
            m_pt  = pt;
        end
        if (m_run) begin
            if (upd_valid) begin
                ui = int'(upd_pc) % DEPTH;
                if (upd_taken) m_ctr[ui] = (m_ctr[ui] < CTR_MAX) ? m_ctr[ui] + 1 : CTR_MAX;
                else           m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
                if (upd_taken != upd_pred_taken && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
            end
        end else begin
            m_ctr[m_init_cnt] = HALF - 1;
            m_init_cnt++;
            if (m_init_cnt == DEPTH) m_run = 1;
        end
        m_ready = m_run;
    endtask

    // Check the combinational offset, advance one edge, check registered outputs.
    task automatic tick();
        #1;
        check("predicted_offset", 32'(predicted_offset), 32'(m_pred()));
        model_step();
        @(posedge clk);
        #1;
        check("not_predicted_offset", 32'(not_predicted_offset), 32'(m_npo));
        check("pred_taken", 32'(pred_taken), 32'(m_pt));
        check("ready", 32'(ready), 32'(m_ready));
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, m_sb);
        check("stat_mispredicts", stat_mispredicts, m_sm);
`endif
    endtask

    task automatic idle();
        stall = 0; halted = 0; opcode = ADD; pc = '0; branch_target = '0;
        upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_pred_taken = 0;
    endtask

    task automatic train(input logic [PC_W-1:0] p, input bit t, input bit ptk);
        idle();
        upd_valid = 1; upd_pc = p; upd_taken = t; upd_pred_taken = ptk;
        tick();
    endtask

    task automatic branch(input logic [4:0] op, input logic [PC_W-1:0] p,
                          input logic [OFFSET_W-1:0] bt);
        idle();
        opcode = op; pc = p; branch_target = bt;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 0;
        idle();
        reset = 1;
        tick();
        tick();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_npo", 32'(not_predicted_offset), 32'd0);
        check("reset_pt", 32'(pred_taken), 32'd0);

        // First init: BTFNT fallback on the first INIT cycle, then ready timing.
        reset = 0;
        for (int n = 1; n <= DEPTH; n++) begin
            if (n == 1) begin
                branch(BT, 16'h0004, 17'h1FFFC);
                #1 check("init_btfnt_pred", 32'(predicted_offset), 32'h1FFFC);
            end else begin
                idle();
            end
            tick();
            if (n == 1) begin
                check("init_btfnt_npo", 32'(not_predicted_offset), 32'd4);
                check("init_btfnt_pt", 32'(pred_taken), 32'd1);
            end
            check("init_ready_timing", 32'(ready), 32'(n == DEPTH));
        end

        // Reset reasserted part-way through INIT restarts the full sequence.
        idle();
        reset = 1; tick(); reset = 0;
        for (int n = 0; n < 30; n++) tick();
        reset = 1; tick(); reset = 0;
        for (int n = 1; n <= DEPTH; n++) begin
            tick();
            check("reinit_ready_timing", 32'(ready), 32'(n == DEPTH));
        end

        // Statistics: four resolutions, one mispredict.
        train(16'h0020, 1, 1);
        train(16'h0021, 0, 0);
        train(16'h0022, 1, 0);
        train(16'h0023, 0, 0);
`ifdef BPU_STATS_EN
        check("stats_branches", stat_branches, 32'd4);
        check("stats_mispredicts", stat_mispredicts, 32'd1);
`endif

        // Default weakly-not-taken, then one taken update flips it.
        branch(BF, 16'h0010, 17'd6);
        #1 check("default_pred", 32'(predicted_offset), 32'd1);
        tick();
        check("default_npo", 32'(not_predicted_offset), 32'd4);
        check("default_pt", 32'(pred_taken), 32'd0);
        train(16'h0010, 1, 0);
        branch(BF, 16'h0010, 17'd6);
        #1 check("trained_pred", 32'(predicted_offset), 32'd6);
        tick();
        check("trained_npo", 32'(not_predicted_offset), 32'h1FFFA);
        check("trained_pt", 32'(pred_taken), 32'd1);

        // Saturation on index 3.
        for (int k = 0; k < 5; k++) train(16'h0003, 1, 1);
        train(16'h0003, 0, 1);
        branch(BT, 16'h0003, 17'd8);
        #1 check("sat_still_taken", 32'(predicted_offset), 32'd8);
        tick();
        train(16'h0003, 0, 1);
        train(16'h0003, 0, 1);
        branch(BT, 16'h0003, 17'd8);
        #1 check("sat_now_not_taken", 32'(predicted_offset), 32'd1);
        tick();

        // JAL correction and stall hold.
        branch(JAL, 16'h0100, 17'd10);
        #1 check("jal_pred", 32'(predicted_offset), 32'd10);
        tick();
        check("jal_npo", 32'(not_predicted_offset), 32'h1FFF7);
        check("jal_pt", 32'(pred_taken), 32'd1);
        for (int k = 0; k < 3; k++) begin
            idle();
            stall = 1;
            tick();
            check("stall_hold_npo", 32'(not_predicted_offset), 32'h1FFF7);
            check("stall_hold_pt", 32'(pred_taken), 32'd1);
        end

        // Aliasing 0x0005/0x0045 and same-cycle read/update of index 5.
        train(16'h0005, 1, 0);
        train(16'h0005, 1, 1);
        branch(BT, 16'h0045, 17'd12);
        #1 check("alias_pred", 32'(predicted_offset), 32'd12);
        tick();
        train(16'h0005, 0, 1);
        branch(BT, 16'h0005, 17'd12);
        upd_valid = 1; upd_pc = 16'h0045; upd_taken = 0; upd_pred_taken = 1;
        #1 check("same_cycle_pre_update", 32'(predicted_offset), 32'd12);
        tick();
        branch(BT, 16'h0005, 17'd12);
        #1 check("post_update_pred", 32'(predicted_offset), 32'd1);
        tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1:    opcode = BT;
                2:       opcode = BF;
                3:       opcode = JAL;
                default: opcode = 5'($urandom_range(0, 31));
            endcase
            pc             = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
            branch_target  = 17'($urandom);
            stall          = ($urandom_range(0, 7) == 0);
            halted         = ($urandom_range(0, 15) == 0);
            upd_valid      = $urandom_range(0, 1) == 1;
            upd_pc         = 16'($urandom_range(0, 127));
            upd_taken      = $urandom_range(0, 1) == 1;
            upd_pred_taken = $urandom_range(0, 1) == 1;
            reset          = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
